exception_sequencer: RTL and testbench

- Drives the status register's write port during exception entry and return; the status register is the consumer.
- Prioritises pending exception causes and saves the faulting PC and user status into shadow registers.
- Switches the CPU to supervisor mode through a status write, then redirects the fetch PC to a per-cause vector.
- On an exception-return request, restores the saved status (back to user mode) and reloads the saved PC.

---
 rtl/exception_sequencer.sv | 138 +++++++++++++
 tb/tb_exception_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/exception_sequencer.sv
// Exception entry/return sequencer: prioritises causes, saves PC and status,
// drives the status-register write port and redirects the fetch PC.
module exception_sequencer #(
    parameter logic [31:0] VECTOR_BASE   = 32'h0000_0100,
    parameter int unsigned VECTOR_STRIDE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  excReq,
    input  logic [31:0] excPc,
    input  logic [31:0] nextPc,
    input  logic        cpuMode,
    input  logic [31:0] statusIn,
    input  logic        eretReq,
    output logic        stall,
    output logic        flush,
    output logic        pcLoad,
    output logic [31:0] pcTarget,
    output logic        srWriteEnable,
    output logic        srWriteSelector,
    output logic [31:0] srData,
    output logic [31:0] epc,
    output logic [31:0] savedStatus,
    output logic [2:0]  cause
);

    localparam int unsigned CAUSE_W = 3;
    localparam logic [CAUSE_W-1:0] CAUSE_DOUBLE = CAUSE_W'(4);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAVE    = 3'd1,
        ENTER   = 3'd2,
        VECTOR  = 3'd3,
        RESTORE = 3'd4,
        RETPC   = 3'd5
    } state_t;

    state_t state, state_next;

    logic [3:0]         sensitive;
    logic               exc_take;
    logic               double_fault;
    logic [CAUSE_W-1:0] take_cause;
    logic               div0_bit;

    // IRQ is masked in supervisor mode; sync causes always count
    always_comb begin
        sensitive    = {excReq[3] & cpuMode, excReq[2:0]};
        exc_take     = |sensitive;
        double_fault = (|excReq[2:0]) & ~cpuMode;
        take_cause   = CAUSE_W'(3);
        if (sensitive[0])      take_cause = CAUSE_W'(0);
        else if (sensitive[1]) take_cause = CAUSE_W'(1);
        else if (sensitive[2]) take_cause = CAUSE_W'(2);
        if (double_fault) take_cause = CAUSE_DOUBLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (exc_take)               state_next = SAVE;
                else if (eretReq && !cpuMode) state_next = RESTORE;
            end
            SAVE:    state_next = ENTER;
            ENTER:   state_next = VECTOR;
            VECTOR:  state_next = IDLE;
            RESTORE: state_next = RETPC;
            RETPC:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture on the accepting edge so SAVE onward sees stable shadow values
    always_ff @(posedge clk) begin
        if (rst) begin
            cause       <= '0;
            epc         <= '0;
            savedStatus <= '0;
        end else if (state == IDLE && exc_take) begin
            cause <= take_cause;
            if (!double_fault) begin
                epc         <= (take_cause == CAUSE_W'(3)) ? nextPc : excPc;
                savedStatus <= statusIn;
            end
        end
    end

    always_comb begin
        div0_bit = (cause == CAUSE_W'(0)) ? 1'b1 : savedStatus[5];
    end

    always_comb begin
        stall           = 1'b0;
        flush           = 1'b0;
        pcLoad          = 1'b0;
        pcTarget        = '0;
        srWriteEnable   = 1'b0;
        srWriteSelector = 1'b0;
        srData          = '0;
        case (state)
            SAVE: begin
                stall = 1'b1;
                flush = 1'b1;
            end
            ENTER: begin
                stall         = 1'b1;
                srWriteEnable = 1'b1;
                srData        = {26'b0, div0_bit, 1'b0, savedStatus[3:0]};
            end
            VECTOR: begin
                stall    = 1'b1;
                pcLoad   = 1'b1;
                pcTarget = VECTOR_BASE + 32'(cause) * 32'(VECTOR_STRIDE);
            end
            RESTORE: begin
                stall           = 1'b1;
                flush           = 1'b1;
                srWriteEnable   = 1'b1;
                srWriteSelector = 1'b1;
                srData          = {savedStatus[31:5], 1'b1, savedStatus[3:0]};
            end
            RETPC: begin
                stall    = 1'b1;
                pcLoad   = 1'b1;
                pcTarget = epc;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer: entry, return, masking, double fault,
// collisions and mid-sequence reset.
module tb_exception_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  excReq;
    logic [31:0] excPc;
    logic [31:0] nextPc;
    logic        cpuMode;
    logic [31:0] statusIn;
    logic        eretReq;
    logic        stall;
    logic        flush;
    logic        pcLoad;
    logic [31:0] pcTarget;
    logic        srWriteEnable;
    logic        srWriteSelector;
    logic [31:0] srData;
    logic [31:0] epc;
    logic [31:0] savedStatus;
    logic [2:0]  cause;

    int total  = 0;
    int passed = 0;
    int wr_cnt = 0;
    int ld_cnt = 0;
    int wr_mark;
    int ld_mark;

    exception_sequencer dut (
        .clk(clk), .rst(rst), .excReq(excReq), .excPc(excPc), .nextPc(nextPc),
        .cpuMode(cpuMode), .statusIn(statusIn), .eretReq(eretReq),
        .stall(stall), .flush(flush), .pcLoad(pcLoad), .pcTarget(pcTarget),
        .srWriteEnable(srWriteEnable), .srWriteSelector(srWriteSelector),
        .srData(srData), .epc(epc), .savedStatus(savedStatus), .cause(cause)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (srWriteEnable) wr_cnt <= wr_cnt + 1;
        if (pcLoad)        ld_cnt <= ld_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; excReq = 4'b0; excPc = '0; nextPc = '0;
        cpuMode = 1'b0; statusIn = '0; eretReq = 1'b0;
        tick(); tick();
        chk("rst_stall", 32'(stall), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_pcload", 32'(pcLoad), 0);
        chk("rst_srwe", 32'(srWriteEnable), 0);
        chk("rst_epc", epc, 0);
        chk("rst_saved", savedStatus, 0);
        chk("rst_cause", 32'(cause), 0);
        rst = 1'b0;
        tick();

        // div-by-0 in user mode
        cpuMode = 1'b1; statusIn = 32'h1B; excPc = 32'h400; nextPc = 32'h404; excReq = 4'b0001;
        tick();
        excReq = 4'b0;
        chk("t1_save_stall", 32'(stall), 1);
        chk("t1_save_flush", 32'(flush), 1);
        chk("t1_save_srwe", 32'(srWriteEnable), 0);
        tick();
        chk("t1_enter_srwe", 32'(srWriteEnable), 1);
        chk("t1_enter_sel", 32'(srWriteSelector), 0);
        chk("t1_enter_data", srData, 32'h2B);
        chk("t1_enter_flush", 32'(flush), 0);
        chk("t1_enter_stall", 32'(stall), 1);
        tick();
        chk("t1_vec_pcload", 32'(pcLoad), 1);
        chk("t1_vec_target", pcTarget, 32'h100);
        chk("t1_vec_srdata", srData, 0);
        chk("t1_vec_stall", 32'(stall), 1);
        chk("t1_epc", epc, 32'h400);
        chk("t1_saved", savedStatus, 32'h1B);
        chk("t1_cause", 32'(cause), 0);
        tick();
        chk("t1_idle_stall", 32'(stall), 0);
        chk("t1_idle_target", pcTarget, 0);

        // exception return from supervisor
        cpuMode = 1'b0; eretReq = 1'b1;
        tick();
        eretReq = 1'b0;
        chk("t4_rest_flush", 32'(flush), 1);
        chk("t4_rest_srwe", 32'(srWriteEnable), 1);
        chk("t4_rest_sel", 32'(srWriteSelector), 1);
        chk("t4_rest_data", srData, 32'h1B);
        tick();
        chk("t4_ret_pcload", 32'(pcLoad), 1);
        chk("t4_ret_target", pcTarget, 32'h400);
        chk("t4_ret_srwe", 32'(srWriteEnable), 0);
        tick();
        chk("t4_idle_stall", 32'(stall), 0);
        cpuMode = 1'b1; eretReq = 1'b1;
        tick();
        chk("t4_user_eret_stall", 32'(stall), 0);
        tick();
        chk("t4_user_eret_stall2", 32'(stall), 0);
        eretReq = 1'b0;

        // priority among multiple causes, then IRQ alone
        statusIn = 32'h1B; excPc = 32'h500; nextPc = 32'h804; excReq = 4'b1110;
        tick();
        excReq = 4'b0;
        chk("t2_cause1", 32'(cause), 1);
        tick();
        chk("t2_enter_data", srData, 32'h0B);
        tick();
        chk("t2_target", pcTarget, 32'h110);
        chk("t2_epc", epc, 32'h500);
        tick();
        excReq = 4'b1000;
        tick();
        excReq = 4'b0;
        chk("t2_cause3", 32'(cause), 3);
        tick(); tick();
        chk("t2_irq_target", pcTarget, 32'h130);
        chk("t2_irq_epc", epc, 32'h804);
        tick();

        // supervisor: IRQ masked, sync cause is a double fault
        cpuMode = 1'b0; excReq = 4'b1000;
        tick();
        chk("t3_mask_stall", 32'(stall), 0);
        tick();
        chk("t3_mask_stall2", 32'(stall), 0);
        excReq = 4'b0100; statusIn = 32'h3F; excPc = 32'h900;
        tick();
        excReq = 4'b0;
        chk("t3_cause4", 32'(cause), 4);
        tick();
        chk("t3_enter_data", srData, 32'h0B);
        tick();
        chk("t3_target", pcTarget, 32'h140);
        chk("t3_epc_kept", epc, 32'h804);
        chk("t3_saved_kept", savedStatus, 32'h1B);
        tick();

        // exception and eret together; re-pulse during ENTER ignored
        cpuMode = 1'b1; statusIn = 32'h1B; excPc = 32'h600; excReq = 4'b0001; eretReq = 1'b1;
        wr_mark = wr_cnt; ld_mark = ld_cnt;
        tick();
        excReq = 4'b0; eretReq = 1'b0;
        chk("t5_save_flush", 32'(flush), 1);
        chk("t5_save_srwe", 32'(srWriteEnable), 0);
        tick();
        chk("t5_enter_sel", 32'(srWriteSelector), 0);
        excReq = 4'b0001;
        tick();
        excReq = 4'b0;
        chk("t5_vec_target", pcTarget, 32'h100);
        tick();
        chk("t5_idle_stall", 32'(stall), 0);
        tick();
        chk("t5_idle_stall2", 32'(stall), 0);
        chk("t5_writes", 32'(wr_cnt - wr_mark), 1);
        chk("t5_loads", 32'(ld_cnt - ld_mark), 1);

        // reset in ENTER
        excReq = 4'b0001;
        tick();
        excReq = 4'b0;
        tick();
        chk("t6_enter_srwe", 32'(srWriteEnable), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_stall", 32'(stall), 0);
        chk("t6_rst_pcload", 32'(pcLoad), 0);
        chk("t6_rst_srwe", 32'(srWriteEnable), 0);
        chk("t6_rst_epc", epc, 0);
        chk("t6_rst_saved", savedStatus, 0);
        tick();
        chk("t6_no_pcload", 32'(pcLoad), 0);
        excReq = 4'b0010; excPc = 32'h700;
        tick();
        excReq = 4'b0;
        chk("t6_cause1", 32'(cause), 1);
        tick(); tick();
        chk("t6_target", pcTarget, 32'h110);
        chk("t6_epc", epc, 32'h700);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
